// File: rtl/i2s_tx.sv
// I2S transmitter: one mono PCM sample per 64-SCLK frame, duplicated into both slots,
// MSB first one SCLK after each LRCLK edge; repeats the last sample on starvation.
module i2s_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 24
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                sclk_o,
  output logic                lrclk_o,
  output logic                sdout_o,
  output logic                underrun_o
);

  localparam int                  DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]          SW6      = 6'(SAMPLE_W);

  logic [DIV_W-1:0]    r_div;
  logic                r_sclk;
  logic                r_lrclk;
  logic                r_sdout;
  logic                r_underrun;
  logic                r_hold_full;
  logic [5:0]          r_bit_cnt;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_active;

  logic                w_tc;
  logic                w_fall;
  logic                w_frame_start;
  logic                w_xfer;
  logic [5:0]          w_bit_next;
  logic [4:0]          w_p;
  logic [SAMPLE_W-1:0] w_shifted;
  logic                w_sd_bit;

  assign w_tc          = (r_div == DIV_LAST);
  assign w_fall        = w_tc && r_sclk;
  assign w_bit_next    = r_bit_cnt + 6'd1;
  assign w_frame_start = w_fall && (w_bit_next == 6'd0);
  assign w_xfer        = valid_i && !r_hold_full;
  assign w_p           = w_bit_next[4:0];

  // Slot position p selects active[SAMPLE_W-p], i.e. the MSB of active shifted left by p-1.
  assign w_shifted = r_active << (w_p - 5'd1);

  always_comb begin
    // NOTE: default first so every path assigns w_sd_bit and no latch is inferred.
    w_sd_bit = 1'b0;
    if ((w_p != 5'd0) && ({1'b0, w_p} <= SW6)) begin
      w_sd_bit = w_shifted[SAMPLE_W-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_div       <= '0;
      r_sclk      <= 1'b0;
      r_lrclk     <= 1'b1;
      r_sdout     <= 1'b0;
      r_underrun  <= 1'b0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= 6'd63;
      r_active    <= '0;
    end else begin
      r_div      <= w_tc ? '0 : r_div + DIV_W'(1);
      r_underrun <= 1'b0;
      if (w_tc) begin
        r_sclk <= ~r_sclk;
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_lrclk   <= w_bit_next[5];
        r_sdout   <= w_sd_bit;
        if (w_frame_start && !r_hold_full) begin
          r_underrun <= 1'b1;
        end
      end
      // ready is low while full, so a load at frame start and a transfer never coincide.
      if (w_frame_start && r_hold_full) begin
        r_active    <= r_hold;
        r_hold_full <= 1'b0;
      end else if (w_xfer) begin
        r_hold_full <= 1'b1;
      end
    end
  end

  // NOTE: the holding data needs no reset; r_hold_full alone decides whether it is ever used.
  always_ff @(posedge clk_i) begin
    if (w_xfer) begin
      r_hold <= sample_i;
    end
  end

  assign ready_o    = ~r_hold_full;
  assign sclk_o     = r_sclk;
  assign lrclk_o    = r_lrclk;
  assign sdout_o    = r_sdout;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus pushes expected frames, a monitor decodes the
// serial stream per frame and compares both slots, slot padding and underrun pulses.
module tb_i2s_tx;

  localparam int CLK_DIV  = 2;
  localparam int SAMPLE_W = 24;

  typedef struct {
    logic [23:0] left;
    logic [23:0] right;
    int          ur;
  } frame_t;

  logic        clk_i    = 1'b0;
  logic        reset_i  = 1'b1;
  logic        valid_i  = 1'b0;
  logic [23:0] sample_i = '0;
  logic        ready_o;
  logic        sclk_o;
  logic        lrclk_o;
  logic        sdout_o;
  logic        underrun_o;

  always #5 clk_i = ~clk_i;

  i2s_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .sample_i   (sample_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sclk_o     (sclk_o),
    .lrclk_o    (lrclk_o),
    .sdout_o    (sdout_o),
    .underrun_o (underrun_o)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  frame_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] slot_word(input logic [31:0] b);
    logic [23:0] w;
    for (int i = 0; i < 24; i++) w[23-i] = b[1+i];
    return w;
  endfunction

  function automatic logic slot_pad(input logic [31:0] b);
    return b[0] | (|b[31:25]);
  endfunction

  // ---------------- monitor ----------------
  logic        m_prev_sclk;
  logic        m_prev_lr;
  int          m_pos;
  logic [31:0] m_bits;
  logic [31:0] m_left_bits;
  bit          m_have_left;
  int          m_ur;

  task automatic compare_frame();
    frame_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("left_word",  32'(slot_word(m_left_bits)), 32'(e.left));
    check("right_word", 32'(slot_word(m_bits)),      32'(e.right));
    check("slot_pad",   32'(slot_pad(m_left_bits) | slot_pad(m_bits)), 32'd0);
    check("underrun_pulses", 32'(m_ur), 32'(e.ur));
  endtask

  initial begin
    m_prev_sclk = 1'b0;
    m_prev_lr   = 1'b1;
    m_pos       = -1;
    m_bits      = '0;
    m_left_bits = '0;
    m_have_left = 1'b0;
    m_ur        = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        m_pos       = -1;
        m_have_left = 1'b0;
        m_prev_lr   = 1'b1;
        m_prev_sclk = 1'b0;
        m_ur        = 0;
      end else begin
        if (lrclk_o != m_prev_lr) begin
          m_pos = 0;
          if (!lrclk_o) begin
            m_ur        = 0;
            m_have_left = 1'b0;
          end
        end
        if (underrun_o) m_ur++;
        if (sclk_o && !m_prev_sclk && m_pos >= 0 && m_pos < 32) begin
          m_bits[m_pos] = sdout_o;
          m_pos++;
          if (m_pos == 32) begin
            if (!lrclk_o) begin
              m_left_bits = m_bits;
              m_have_left = 1'b1;
            end else if (m_have_left) begin
              compare_frame();
            end
          end
        end
        m_prev_sclk = sclk_o;
        m_prev_lr   = lrclk_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [23:0] s, input int ur);
    frame_t f;
    f.left  = s;
    f.right = s;
    f.ur    = ur;
    exp_q.push_back(f);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sclk"},     32'(sclk_o),     32'd0);
    check({tag, "_lrclk"},    32'(lrclk_o),    32'd1);
    check({tag, "_sdout"},    32'(sdout_o),    32'd0);
    check({tag, "_ready"},    32'(ready_o),    32'd1);
    check({tag, "_underrun"}, 32'(underrun_o), 32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic accept_one(input logic [23:0] s);
    valid_i  = 1'b1;
    sample_i = s;
    tick();
    valid_i  = 1'b0;
    sample_i = '0;
  endtask

  task automatic wait_lr(input logic level, input string name);
    int c = 0;
    while (lrclk_o != level && c < 400) begin
      tick();
      c++;
    end
    check({name, "_lr_timeout"}, 32'(lrclk_o), 32'(level));
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      tick();
      k++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [23:0] b2b[3] = '{24'h000001, 24'h000002, 24'h000003};

  initial begin
    int c;
    bit early;
    int k;
    int cyc;
    bit acc;

    // Idle timing; a sample offered during reset must be discarded.
    valid_i  = 1'b1;
    sample_i = 24'hFFFFFF;
    reset_i  = 1'b1;
    tick();
    tick();
    check_reset_state("rst");
    valid_i  = 1'b0;
    sample_i = '0;
    reset_i  = 1'b0;
    push_exp(24'h0, 1);
    push_exp(24'h0, 1);
    c = 0;
    while (lrclk_o && c < 50) begin
      tick();
      c++;
    end
    check("first_fs_latency", 32'(c), 32'(2 * CLK_DIV));
    check("ready_after_rst_xfer", 32'(ready_o), 32'd1);
    c = 0;
    while (!sclk_o && c < 50) begin tick(); c++; end
    while (sclk_o && c < 50) begin tick(); c++; end
    while (!sclk_o && c < 50) begin tick(); c++; end
    c = 0;
    while (sclk_o && c < 50) begin tick(); c++; end
    while (!sclk_o && c < 50) begin tick(); c++; end
    check("sclk_period", 32'(c), 32'(2 * CLK_DIV));
    wait_lr(1'b1, "idle_rise");
    c = 0;
    while (lrclk_o && c < 400) begin tick(); c++; end
    check("lrclk_half_frame", 32'(c), 32'(64 * CLK_DIV));
    drain("idle");

    // Single sample before the first frame start.
    do_reset();
    push_exp(24'hA5C3F0, 0);
    accept_one(24'hA5C3F0);
    check("ready_low_after_accept", 32'(ready_o), 32'd0);
    early = 1'b0;
    c = 0;
    while (lrclk_o && c < 50) begin
      if (ready_o) early = 1'b1;
      tick();
      c++;
    end
    check("ready_low_until_fs", 32'(early), 32'd0);
    check("ready_high_after_fs", 32'(ready_o), 32'd1);
    drain("single");

    // Starvation repeats the last sample with an underrun each frame.
    do_reset();
    push_exp(24'h800001, 0);
    push_exp(24'h800001, 1);
    push_exp(24'h800001, 1);
    accept_one(24'h800001);
    drain("starve");

    // Back-to-back with valid held; junk on sample_i while ready is low.
    do_reset();
    push_exp(24'h000001, 0);
    push_exp(24'h000002, 0);
    push_exp(24'h000003, 0);
    valid_i = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 2000) begin
      acc = ready_o;
      sample_i = acc ? b2b[k] : (24'h5A0000 | 24'(cyc));
      tick();
      if (acc) k++;
      cyc++;
    end
    valid_i  = 1'b0;
    sample_i = '0;
    check("b2b_accepted", 32'(k), 32'd3);
    drain("b2b");

    // Mid-frame reset at bit_cnt = 40 with the holding register full.
    do_reset();
    accept_one(24'h111111);
    wait_lr(1'b0, "mid_fs");
    accept_one(24'h222222);
    check("mid_hold_full", 32'(ready_o), 32'd0);
    wait_lr(1'b1, "mid_right");
    repeat (8 * 2 * CLK_DIV) tick();
    reset_i = 1'b1;
    tick();
    check_reset_state("mid_rst");
    reset_i = 1'b0;
    push_exp(24'h0, 1);
    c = 0;
    while (lrclk_o && c < 50) begin
      tick();
      c++;
    end
    check("mid_first_fs_latency", 32'(c), 32'(2 * CLK_DIV));
    drain("mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
